// File: rtl/crc5_pkg.sv
// Shared constants and the serial CRC-5-USB update step for the token scheduler.
package crc5_pkg;

    localparam logic [4:0] CRC5_POLY     = 5'b00101;
    localparam logic [4:0] CRC5_INIT     = 5'b11111;
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;
    localparam int         PAYLOAD_W     = 11;
    localparam int         FRAME_W       = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CRC     = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        logic fb;
        fb = b ^ c[4];
        return {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    endfunction

endpackage

// File: rtl/crc5_token_scheduler_if.sv
// Requester handshake and serial transmit bundle of the CRC-5 token scheduler.
interface crc5_token_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    // req_valid[i] holds while requester i offers req_data slot i; the slot is
    // accepted in the single cycle where req_valid[i] and req_ready[i] are both high.
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*11-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                tx_bit;
    logic                tx_en;
    logic                tx_sof;
    logic                busy;
    logic                done;
    logic [ID_W-1:0]     done_id;
    logic                crc_ok;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_bit, tx_en, tx_sof, busy, done, done_id, crc_ok
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_bit, tx_en, tx_sof, busy, done, done_id, crc_ok
    );
endinterface

// File: rtl/crc5_serial_core.sv
// One-bit-per-cycle CRC-5-USB register; init has priority over en.
module crc5_serial_core
    import crc5_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       en,
    input  logic       din,
    output logic [4:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc <= CRC5_INIT;
        end else if (en) begin
            crc <= crc5_step(crc, din);
        end
    end

endmodule

// File: rtl/crc5_token_scheduler.sv
// Round-robin arbiter feeding one serial lane with 11-bit payload + inverted CRC-5 frames.
module crc5_token_scheduler
    import crc5_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GAP   = 2,
    parameter int ID_W  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inject_err,
    output logic [1:0] o_state,
    crc5_token_scheduler_if.slave bus
);

    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic [3:0]           r_gap_cnt;
    logic [ID_W-1:0]      r_rr;
    logic [ID_W-1:0]      r_id;
    logic [PAYLOAD_W-1:0] r_payload;
    logic                 r_done;
    logic [ID_W-1:0]      r_done_id;
    logic                 r_crc_ok;

    logic                 w_found;
    logic [ID_W-1:0]      w_grant;
    logic [PAYLOAD_W-1:0] w_grant_data;
    logic                 w_capture;
    logic [N_REQ-1:0]     w_ready;
    logic                 w_tx_bit;
    logic                 w_tx_en;
    logic                 w_tx_sof;
    logic                 w_gen_en;
    logic                 w_chk_din;
    logic [4:0]           w_gen_crc;
    logic [4:0]           w_chk_crc;

    // First valid requester at or after the round-robin pointer, with wrap-around.
    always_comb begin
        int idx;
        idx          = 0;
        w_found      = 1'b0;
        w_grant      = '0;
        w_grant_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(r_rr) + k) % N_REQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found      = 1'b1;
                w_grant      = ID_W'(idx);
                w_grant_data = bus.req_data[idx*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    assign w_capture = (r_state == ST_IDLE) && w_found && !rst;

    always_comb begin
        w_ready = '0;
        if (w_capture) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_tx_bit = 1'b0;
        w_tx_en  = 1'b0;
        w_tx_sof = 1'b0;
        case (r_state)
            ST_PAYLOAD: begin
                w_tx_bit = r_payload[r_cnt];
                w_tx_en  = 1'b1;
                w_tx_sof = (r_cnt == 4'd0);
            end
            ST_CRC: begin
                w_tx_bit = ~w_gen_crc[3'd4 - r_cnt[2:0]];
                w_tx_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_gen_en  = (r_state == ST_PAYLOAD);
    assign w_chk_din = w_tx_bit ^ i_inject_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_gap_cnt <= 4'd0;
            r_rr      <= '0;
            r_id      <= '0;
            r_payload <= '0;
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_crc_ok  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_done_id <= '0;
            r_crc_ok  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_payload <= w_grant_data;
                        r_id      <= w_grant;
                        r_rr      <= ID_W'((int'(w_grant) + 1) % N_REQ);
                        r_cnt     <= 4'd0;
                        r_state   <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (r_cnt == 4'd10) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_CRC;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_CRC: begin
                    if (r_cnt == 4'd4) begin
                        // Residual includes the last CRC bit, which the checker absorbs on this edge.
                        r_cnt     <= 4'd0;
                        r_gap_cnt <= 4'd0;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                        r_crc_ok  <= (crc5_step(w_chk_crc, w_chk_din) == CRC5_RESIDUAL);
                        r_state   <= (GAP > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 4'(GAP - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    crc5_serial_core u_gen (
        .clk  (clk),
        .rst  (rst),
        .init (w_capture),
        .en   (w_gen_en),
        .din  (w_tx_bit),
        .crc  (w_gen_crc)
    );

    crc5_serial_core u_chk (
        .clk  (clk),
        .rst  (rst),
        .init (w_capture),
        .en   (w_tx_en),
        .din  (w_chk_din),
        .crc  (w_chk_crc)
    );

    assign bus.req_ready = w_ready;
    assign bus.tx_bit    = w_tx_bit;
    assign bus.tx_en     = w_tx_en;
    assign bus.tx_sof    = w_tx_sof;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.done_id   = r_done_id;
    assign bus.crc_ok    = r_crc_ok;
    assign o_state       = r_state;

endmodule

// File: tb/tb_crc5_token_scheduler.sv
// Directed bench for crc5_token_scheduler: GAP=2 instance with a frame scoreboard, GAP=0 instance for back-to-back spacing.
module tb_crc5_token_scheduler;

    localparam int GAP_A = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       inj_a;
    logic       inj_b;
    logic [1:0] st_a;
    logic [1:0] st_b;

    always #5 clk = ~clk;

    crc5_token_scheduler_if #(.N_REQ(4), .ID_W(2)) bus_a ();
    crc5_token_scheduler_if #(.N_REQ(4), .ID_W(2)) bus_b ();

    crc5_token_scheduler #(.N_REQ(4), .GAP(GAP_A), .ID_W(2)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .i_inject_err (inj_a),
        .o_state      (st_a),
        .bus          (bus_a)
    );

    crc5_token_scheduler #(.N_REQ(4), .GAP(0), .ID_W(2)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .i_inject_err (inj_b),
        .o_state      (st_b),
        .bus          (bus_b)
    );

    int checks = 0;
    int errors = 0;

    // Entry layout: {crc_ok, done_id[1:0], frame[15:0]}; frame bit i is the i-th bit on the line.
    logic [18:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_frame(input logic [10:0] p);
        logic [4:0]  c;
        logic [15:0] f;
        logic        fb;
        c = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            fb = p[i] ^ c[4];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        f[10:0] = p;
        for (int k = 0; k < 5; k++) f[11+k] = ~c[4-k];
        return f;
    endfunction

    // ---------------- monitor / scoreboard (instance A) ----------------
    int          bit_cnt = 0;
    int          cyc = 0;
    int          last_bit_cyc = -1;
    bit          chk_spacing = 1'b0;
    logic [15:0] rx = '0;
    logic [18:0] e;

    always @(negedge clk) begin
        cyc++;
        if (!chk_spacing) last_bit_cyc = -1;
        if (rst) begin
            bit_cnt = 0;
        end else begin
            if (bus_a.req_ready != 4'b0000) begin
                check("ready_onehot", $countones(bus_a.req_ready), 1);
                check("ready_in_idle", {30'b0, st_a}, 0);
            end
            if (bus_a.tx_en) begin
                if (bus_a.tx_sof) begin
                    if (chk_spacing && last_bit_cyc >= 0)
                        check("frame_spacing", cyc - last_bit_cyc - 1, GAP_A + 1);
                    bit_cnt = 0;
                end
                if (bit_cnt < 16) rx[bit_cnt] = bus_a.tx_bit;
                bit_cnt++;
                last_bit_cyc = cyc;
            end
            if (bus_a.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done id %0d, expected no frame", bus_a.done_id);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bits", {16'b0, rx}, {16'b0, e[15:0]});
                    check("done_id", {30'b0, bus_a.done_id}, {30'b0, e[17:16]});
                    check("crc_ok", {31'b0, bus_a.crc_ok}, {31'b0, e[18]});
                    check("frame_len", bit_cnt, 16);
                end
                bit_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic v, input logic [10:0] d);
        bus_a.req_valid[i]         = v;
        bus_a.req_data[11*i +: 11] = d;
    endtask

    task automatic wait_grant(input int i);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (bus_a.req_ready[i]) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no req_ready[%0d], expected a grant", i);
        end
    endtask

    task automatic wait_any_ready(output logic [3:0] r);
        r = 4'b0000;
        for (int n = 0; n < 60 && r == 4'b0000; n++) begin
            @(negedge clk);
            r = bus_a.req_ready;
        end
    endtask

    task automatic send_one(input int i, input logic [10:0] d);
        set_req(i, 1'b1, d);
        wait_grant(i);
        @(posedge clk);
        #1;
        set_req(i, 1'b0, 11'($urandom_range(0, 2047)));
        @(negedge clk);
        check("sof_latency", {31'b0, bus_a.tx_sof}, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (st_a == 2'd0 && exp_q.size() == 0 && !bus_a.done) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d frames pending, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  r;
        logic [10:0] rr_pl [4];
        int          rr_order [5];
        bit          done_seen;
        int          readies, sofs, low_run;
        logic        prev_ready, prev_en;
        bit          seen_frame;

        rr_pl    = '{11'h123, 11'h456, 11'h789, 11'h0AB};
        rr_order = '{0, 1, 2, 3, 0};

        rst             = 1'b1;
        inj_a           = 1'b0;
        inj_b           = 1'b0;
        bus_a.req_valid = '0;
        bus_a.req_data  = '0;
        bus_b.req_valid = '0;
        bus_b.req_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_tx_en", {31'b0, bus_a.tx_en}, 0);
        check("rst_tx_sof", {31'b0, bus_a.tx_sof}, 0);
        check("rst_tx_bit", {31'b0, bus_a.tx_bit}, 0);
        check("rst_busy", {31'b0, bus_a.busy}, 0);
        check("rst_done", {31'b0, bus_a.done}, 0);
        check("rst_done_id", {30'b0, bus_a.done_id}, 0);
        check("rst_crc_ok", {31'b0, bus_a.crc_ok}, 0);
        check("rst_ready", {28'b0, bus_a.req_ready}, 0);
        check("rst_state", {30'b0, st_a}, 0);
        @(posedge clk);
        #1;

        // payload 0x000: CRC field on the line is 0,1,0,0,0
        exp_q.push_back({1'b1, 2'd1, 16'h1000});
        send_one(1, 11'h000);
        wait_idle();

        // payload 0x715 (addr 0x15, endp 0xE): CRC field 1,0,1,1,1
        exp_q.push_back({1'b1, 2'd2, 16'hEF15});
        send_one(2, 11'h715);
        wait_idle();

        // all requesters valid from rr=0: grants 0,1,2,3,0 with GAP+1 idle cycles between frames
        do_reset();
        for (int k = 0; k < 5; k++)
            exp_q.push_back({1'b1, 2'(rr_order[k]), model_frame(rr_pl[rr_order[k]])});
        chk_spacing = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, rr_pl[i]);
        for (int k = 0; k < 5; k++) begin
            wait_any_ready(r);
            check("rr_order", {28'b0, r}, 32'(1) << rr_order[k]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 11'h000);
        wait_idle();
        chk_spacing = 1'b0;

        // single-bit error on the self-check input only
        exp_q.push_back({1'b0, 2'd3, model_frame(11'h2A5)});
        set_req(3, 1'b1, 11'h2A5);
        wait_grant(3);
        @(posedge clk);
        #1;
        set_req(3, 1'b0, 11'h000);
        inj_a = 1'b1;
        @(posedge clk);
        #1;
        inj_a = 1'b0;
        wait_idle();

        // reset during PAYLOAD cnt=5 aborts the frame
        set_req(1, 1'b1, 11'h3C3);
        wait_grant(1);
        @(posedge clk);
        #1;
        set_req(1, 1'b0, 11'h000);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx_en", {31'b0, bus_a.tx_en}, 0);
        check("abort_busy", {31'b0, bus_a.busy}, 0);
        check("abort_state", {30'b0, st_a}, 0);
        done_seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus_a.done) done_seen = 1'b1;
        end
        check("abort_no_done", {31'b0, done_seen}, 0);
        @(posedge clk);
        #1;

        // rr back at 0: with 1 and 3 valid, 1 wins first
        exp_q.push_back({1'b1, 2'd1, model_frame(11'h0F0)});
        exp_q.push_back({1'b1, 2'd3, model_frame(11'h70F)});
        set_req(1, 1'b1, 11'h0F0);
        set_req(3, 1'b1, 11'h70F);
        wait_any_ready(r);
        check("rr_after_reset", {28'b0, r}, 32'h2);
        @(posedge clk);
        #1;
        set_req(1, 1'b0, 11'h000);
        wait_grant(3);
        @(posedge clk);
        #1;
        set_req(3, 1'b0, 11'h000);
        wait_idle();

        // GAP=0 instance, one requester held valid
        bus_b.req_data[10:0] = 11'h555;
        bus_b.req_valid      = 4'b0001;
        readies    = 0;
        sofs       = 0;
        low_run    = 0;
        prev_ready = 1'b0;
        prev_en    = 1'b0;
        seen_frame = 1'b0;
        for (int n = 0; n < 200 && sofs < 4; n++) begin
            @(negedge clk);
            if (bus_b.req_ready != 4'b0000) begin
                check("b_ready_onehot", {28'b0, bus_b.req_ready}, 32'h1);
                check("b_ready_pulse", {31'b0, prev_ready}, 0);
                readies++;
            end
            if (bus_b.done) begin
                check("b_done_id", {30'b0, bus_b.done_id}, 0);
                check("b_crc_ok", {31'b0, bus_b.crc_ok}, 1);
            end
            if (bus_b.tx_en) begin
                if (!prev_en) begin
                    if (seen_frame) check("b_idle_gap", low_run, 1);
                    seen_frame = 1'b1;
                    sofs++;
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_ready = bus_b.req_ready[0];
            prev_en    = bus_b.tx_en;
        end
        check("b_frames", sofs, 4);
        check("b_ready_per_frame", readies, sofs);
        @(posedge clk);
        #1;
        bus_b.req_valid = 4'b0000;
        repeat (40) @(posedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
